// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : 4-digit multiplexed 7-segment driver. Scans digits with an
//                internal prescaler, latches a new 16-bit frame only at frame
//                boundaries (tear-free), and blanks anodes at the start of each
//                digit slot to suppress ghosting. Outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 100000,  // clk cycles per digit slot (>= 2)
    parameter int BLANK      = 16,      // blanked cycles at start of slot (< SCAN_DIV)
    parameter int ACTIVE_LOW = 1        // 1: an/seg/dp active-low
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dataBus,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic           POL      = (ACTIVE_LOW != 0);
    localparam logic [3:0]     AN_OFF   = {4{POL}};
    localparam logic [6:0]     SEG_OFF  = {7{POL}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      samp_q;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             tick;
    logic             stable;
    logic             visible;
    logic [3:0]       nibble;

    // Hex digit to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick   = (cnt_q == CNT_LAST);
    // Two consecutive equal samples of the foreign-domain bus count as settled.
    assign stable = (samp_q == dataBus);

    // With no blanking window the slot is visible from its first cycle.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign visible = en;
        end else begin : g_blank
            assign visible = en && (cnt_q >= CNT_W'(BLANK));
        end
    endgenerate

    // Select the nibble for the current digit slot; idx 0 is the rightmost.
    always_comb begin
        nibble = 4'h0;
        case (idx_q)
            2'd0:    nibble = shadow_q[3:0];
            2'd1:    nibble = shadow_q[7:4];
            2'd2:    nibble = shadow_q[11:8];
            default: nibble = shadow_q[15:12];
        endcase
    end

    // Next-state: prescaler, digit index, frame latch and output patterns.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        // A torn sample at the boundary is skipped; the next frame retries.
        shadow_d = (tick && (idx_q == 2'd3) && stable) ? samp_q : shadow_q;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        if (visible) begin
            an_d  = (4'b0001 << idx_q) ^ AN_OFF;
            seg_d = hex_decode(nibble) ^ SEG_OFF;
        end
    end

    // State and output registers; reset forces the display fully off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            samp_q   <= 16'h0000;
            shadow_q <= 16'h0000;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            samp_q   <= dataBus;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = POL;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver. A reference model
//                derives expected an/seg/dp from the elapsed cycle count and
//                pushes them into a queue; a monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int BL = 1;
    localparam int AL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dataBus;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset release and the frame currently shown.
    int          n_edges = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_prev   = 16'h0000;
    logic [11:0] exp_q[$];

    seg7_scan_driver #(
        .SCAN_DIV  (SD),
        .BLANK     (BL),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .dataBus(dataBus),
        .en     (en),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_tbl(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[h];
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the output after edge k reflects slot position (k-1)
    // of the scan sequence, with a frame boundary every 4*SD edges.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n_edges  = 0;
                m_shadow = 16'h0000;
                m_prev   = 16'h0000;
                exp_q.delete();
            end else begin
                int         pos, digit;
                logic       vis;
                logic [3:0] e_an;
                logic [6:0] e_seg;
                logic [3:0] nib;
                pos   = n_edges % SD;
                digit = (n_edges / SD) % 4;
                vis   = en && (pos >= BL);
                nib   = 4'((m_shadow >> (4 * digit)) & 16'h000F);
                e_an  = vis ? ~(4'(1 << digit)) : 4'hF;
                e_seg = vis ? ~hex_tbl(nib) : 7'h7F;
                exp_q.push_back({e_an, e_seg, 1'b1});
                n_edges++;
                if ((n_edges % (4 * SD)) == 0 && m_prev == dataBus)
                    m_shadow = dataBus;
                m_prev = dataBus;
            end
        end
    end

    // Monitor: one output word per clock, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("scan_out", {an, seg, dp}, e);
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        dataBus = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an",  {8'h00, an},  {8'h00, 4'hF});
        check("reset_seg", {5'h00, seg}, {5'h00, 7'h7F});
        check("reset_dp",  {11'h000, dp}, 12'h001);
        @(negedge clk);
        rst = 1'b0;

        // First frame shows zeros, then 1234 is latched.
        run(40);

        // Tear-free update: change while digit 1 is being scanned.
        for (int i = 0; i < 64; i++) begin
            if (((n_edges / SD) % 4) == 1) break;
            @(negedge clk);
        end
        dataBus = 16'h2341;
        run(40);

        // Unstable sample: change right before the frame-boundary edge.
        for (int i = 0; i < 64; i++) begin
            if ((n_edges % (4 * SD)) == (4 * SD - 1)) break;
            @(negedge clk);
        end
        dataBus = 16'hABCD;
        run(48);

        // Enable off mid-slot, counters keep running.
        run(2);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(20);

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_an",  {8'h00, an},  {8'h00, 4'hF});
        check("async_seg", {5'h00, seg}, {5'h00, 7'h7F});
        check("async_dp",  {11'h000, dp}, 12'h001);
        rst = 1'b0;
        run(24);

        // Decode sweep across all sixteen digits.
        dataBus = 16'h0123; run(40);
        dataBus = 16'h4567; run(40);
        dataBus = 16'h89AB; run(40);
        dataBus = 16'hCDEF; run(40);

        // Randomised traffic on data and enable.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) dataBus = 16'($urandom);
            if ($urandom_range(0, 29) == 0) en = ~en;
        end

        run(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
